sub_arbiter: RTL and testbench

- Round-robin scheduler that shares one registered 16-bit subtract/compare unit (left - right, plus a left<right flag) among NREQ requesters.
- Captures the winning requester's operands and drives them to the unit.
- Waits out the unit's register latency, then returns the difference and the compare flag tagged with the requester ID.
- Sits between the control-path clients and the single subtractor instance. One operation in flight at a time.

---
 rtl/sub_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_sub_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_arbiter.sv
// rtl/sub_arbiter.sv - round-robin front end sharing one registered subtract/compare unit
//
// Purpose:
//   Arbitrates NREQ requesters onto a single external subtractor (left - right
//   plus an unsigned left<right flag). One operation is in flight at a time:
//   the winner's operands are registered onto sub_left/sub_right, the block
//   waits SUB_LAT cycles for the unit, captures its result and returns it
//   tagged with the requester ID.
//
// Ports:
//   clock          rising-edge clock
//   nreset         asynchronous active-low reset
//   req            per-requester request level
//   left_bus       minuend per requester, requester i at [i*WORD_WIDTH +: WORD_WIDTH]
//   right_bus      subtrahend per requester, same packing
//   gnt            one-hot single-cycle grant (operands accepted)
//   busy           high from the grant cycle through the response cycle
//   rsp_valid      single-cycle response strobe
//   rsp_id         requester owning the response
//   rsp_data       left - right modulo 2**WORD_WIDTH
//   rsp_neg        left < right (unsigned)
//   sub_left       subtractor left operand
//   sub_right      subtractor right operand
//   sub_data_in    subtractor difference
//   sub_compare_in subtractor compare flag

module sub_arbiter #(
    parameter int WORD_WIDTH = 16,
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int SUB_LAT    = 1
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WORD_WIDTH-1:0] left_bus,
    input  logic [NREQ*WORD_WIDTH-1:0] right_bus,
    output logic [NREQ-1:0]            gnt,
    output logic                       busy,
    output logic                       rsp_valid,
    output logic [IDW-1:0]             rsp_id,
    output logic [WORD_WIDTH-1:0]      rsp_data,
    output logic                       rsp_neg,
    output logic [WORD_WIDTH-1:0]      sub_left,
    output logic [WORD_WIDTH-1:0]      sub_right,
    input  logic [WORD_WIDTH-1:0]      sub_data_in,
    input  logic                       sub_compare_in
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // SUB_LAT is at most 7, so three bits cover the latency counter.
    localparam int            CW       = 3;
    localparam logic [CW-1:0] LAT_LOAD = CW'(SUB_LAT);

    state_t                 state_q,     state_d;
    logic [IDW-1:0]         ptr_q,       ptr_d;
    logic [CW-1:0]          cnt_q,       cnt_d;
    logic [IDW-1:0]         id_q,        id_d;
    logic [NREQ-1:0]        gnt_q,       gnt_d;
    logic                   busy_q,      busy_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]         rsp_id_q,    rsp_id_d;
    logic [WORD_WIDTH-1:0]  rsp_data_q,  rsp_data_d;
    logic                   rsp_neg_q,   rsp_neg_d;
    logic [WORD_WIDTH-1:0]  sub_left_q,  sub_left_d;
    logic [WORD_WIDTH-1:0]  sub_right_q, sub_right_d;

    // Arbitration signals
    logic [NREQ-1:0]       below_ptr;
    logic [NREQ-1:0]       masked_req;
    logic [IDW-1:0]        first_masked;
    logic [IDW-1:0]        first_any;
    logic [IDW-1:0]        win_id;
    logic [NREQ-1:0]       win_onehot;
    logic [WORD_WIDTH-1:0] win_left;
    logic [WORD_WIDTH-1:0] win_right;
    logic [IDW-1:0]        ptr_next;

    // Round-robin pick: requests at or above the pointer take precedence;
    // if none of those are set the lowest request overall wins, which is the
    // wrap-around case of the upward scan.
    always_comb begin
        below_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            below_ptr[i] = (IDW'(i) < ptr_q);
        end
        masked_req = req & ~below_ptr;

        first_masked = '0;
        first_any    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (masked_req[i]) begin
                first_masked = IDW'(i);
            end
            if (req[i]) begin
                first_any = IDW'(i);
            end
        end
        win_id = (|masked_req) ? first_masked : first_any;

        win_onehot = '0;
        win_left   = '0;
        win_right  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_id) begin
                win_onehot[i] = 1'b1;
                win_left      = left_bus[i*WORD_WIDTH +: WORD_WIDTH];
                win_right     = right_bus[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end

        ptr_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_neg_d   = rsp_neg_q;
        sub_left_d  = sub_left_q;
        sub_right_d = sub_right_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    sub_left_d  = win_left;
                    sub_right_d = win_right;
                    gnt_d       = win_onehot;
                    id_d        = win_id;
                    busy_d      = 1'b1;
                    cnt_d       = LAT_LOAD;
                    ptr_d       = ptr_next;
                    state_d     = S_WAIT;
                end
            end

            S_WAIT: begin
                // The count was loaded with SUB_LAT, so leaving at 1 spends
                // exactly SUB_LAT cycles here; the <= guards a zero count.
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_CAPT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_CAPT: begin
                rsp_data_d  = sub_data_in;
                rsp_neg_d   = sub_compare_in;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end

            S_RESP: begin
                // No arbitration here: requests are only evaluated in IDLE.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_neg_q   <= 1'b0;
            sub_left_q  <= '0;
            sub_right_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_neg_q   <= rsp_neg_d;
            sub_left_q  <= sub_left_d;
            sub_right_q <= sub_right_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_neg   = rsp_neg_q;
    assign sub_left  = sub_left_q;
    assign sub_right = sub_right_q;

endmodule

// File: tb/tb_sub_arbiter.sv
// tb/tb_sub_arbiter.sv - scoreboard bench for sub_arbiter at SUB_LAT=1 and SUB_LAT=3
module tb_sub_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        neg;
    } exp_t;

    logic clock  = 1'b0;
    logic nreset = 1'b1;
    int   cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [N-1:0]   req       [2];
    logic [N*W-1:0] lbus      [2];
    logic [N*W-1:0] rbus      [2];
    logic [N-1:0]   gnt       [2];
    logic           busy      [2];
    logic           rsp_valid [2];
    logic [1:0]     rsp_id    [2];
    logic [W-1:0]   rsp_data  [2];
    logic           rsp_neg   [2];
    logic [W-1:0]   sub_l     [2];
    logic [W-1:0]   sub_r     [2];
    logic [W-1:0]   sub_d     [2];
    logic           sub_cmp   [2];
    logic [W:0]     pipe      [2][3];

    sub_arbiter #(.WORD_WIDTH(16), .NREQ(4), .IDW(2), .SUB_LAT(1)) u_dut1 (
        .clock(clock), .nreset(nreset), .req(req[0]),
        .left_bus(lbus[0]), .right_bus(rbus[0]), .gnt(gnt[0]), .busy(busy[0]),
        .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]), .rsp_data(rsp_data[0]),
        .rsp_neg(rsp_neg[0]), .sub_left(sub_l[0]), .sub_right(sub_r[0]),
        .sub_data_in(sub_d[0]), .sub_compare_in(sub_cmp[0])
    );

    sub_arbiter #(.WORD_WIDTH(16), .NREQ(4), .IDW(2), .SUB_LAT(3)) u_dut3 (
        .clock(clock), .nreset(nreset), .req(req[1]),
        .left_bus(lbus[1]), .right_bus(rbus[1]), .gnt(gnt[1]), .busy(busy[1]),
        .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]), .rsp_data(rsp_data[1]),
        .rsp_neg(rsp_neg[1]), .sub_left(sub_l[1]), .sub_right(sub_r[1]),
        .sub_data_in(sub_d[1]), .sub_compare_in(sub_cmp[1])
    );

    // External subtractor: registered, SUB_LAT stages deep.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            pipe[k][0] <= {sub_l[k] < sub_r[k], sub_l[k] - sub_r[k]};
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign sub_d[0]   = pipe[0][0][W-1:0];
    assign sub_cmp[0] = pipe[0][0][W];
    assign sub_d[1]   = pipe[1][2][W-1:0];
    assign sub_cmp[1] = pipe[1][2][W];

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Reference model state (driver-owned)
    logic [N-1:0] pend   [2];
    logic [N-1:0] glitch [2];
    logic [W-1:0] opl    [2][N];
    logic [W-1:0] opr    [2][N];
    int           ptr    [2];
    int           lo     [2];
    int           hi     [2];
    int           free_e [2];
    int           gwin   [2];
    int           rearm  [2];
    exp_t         gq     [2][$];
    exp_t         rq     [2][$];
    logic         drv_fail = 1'b0;
    logic         end_req  = 1'b0;
    logic         end_done = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_op(input int k, input int i, input logic [15:0] l, input logic [15:0] r);
        pend[k][i] = 1'b1;
        opl[k][i]  = l;
        opr[k][i]  = r;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            gq[k].delete();
            rq[k].delete();
            ptr[k]    = 0;
            lo[k]     = 1;
            hi[k]     = 0;
            free_e[k] = 0;
            gwin[k]   = -1;
        end
    endtask

    // Drive inputs for the current cycle and predict the next edge.
    task automatic apply();
        exp_t e;
        int   w;
        for (int k = 0; k < 2; k++) begin
            req[k] = pend[k] | glitch[k];
            for (int i = 0; i < N; i++) begin
                lbus[k][i*W +: W] = pend[k][i] ? opl[k][i] : 16'($urandom);
                rbus[k][i*W +: W] = pend[k][i] ? opr[k][i] : 16'($urandom);
            end
            if (nreset && (cyc + 1 >= free_e[k]) && (pend[k] != '0)) begin
                w = -1;
                for (int j = 0; j < N; j++) begin
                    if (w < 0 && pend[k][(ptr[k] + j) % N]) w = (ptr[k] + j) % N;
                end
                e.cyc = cyc + 1; e.id = w; e.a = opl[k][w]; e.b = opr[k][w]; e.neg = 1'b0;
                gq[k].push_back(e);
                e.cyc = cyc + 2 + lat(k);
                e.a   = opl[k][w] - opr[k][w];
                e.b   = '0;
                e.neg = (opl[k][w] < opr[k][w]);
                rq[k].push_back(e);
                ptr[k]    = (w + 1) % N;
                lo[k]     = cyc + 1;
                hi[k]     = cyc + 2 + lat(k);
                free_e[k] = cyc + 4 + lat(k);
                gwin[k]   = w;
            end
        end
    endtask

    task automatic tick();
        apply();
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (gwin[k] >= 0) begin
                pend[k][gwin[k]] = 1'b0;
                if (rearm[k] > 0 && gwin[k] == 0) begin
                    set_op(k, 0, rnd_op(), rnd_op());
                    rearm[k]--;
                end
            end
            gwin[k]   = -1;
            glitch[k] = '0;
        end
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (((pend[0] | pend[1]) != '0 || cyc <= hi[0] || cyc <= hi[1]) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) drv_fail = 1'b1;
    endtask

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT should present an output.
    initial begin
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                if (!nreset) begin
                    chk("reset_outputs", k,
                        64'({gnt[k], busy[k], rsp_valid[k], rsp_id[k], rsp_data[k],
                             rsp_neg[k], sub_l[k], sub_r[k]}), 64'd0);
                end else begin
                    chk("busy", k, 64'(busy[k]), 64'(cyc >= lo[k] && cyc <= hi[k]));
                    if (gq[k].size() > 0 && gq[k][0].cyc == cyc) begin
                        chk("gnt_operands", k, 64'({gnt[k], sub_l[k], sub_r[k]}),
                            64'({4'(1 << gq[k][0].id), gq[k][0].a, gq[k][0].b}));
                        void'(gq[k].pop_front());
                    end else begin
                        chk("no_gnt", k, 64'(gnt[k]), 64'd0);
                    end
                    if (rq[k].size() > 0 && rq[k][0].cyc == cyc) begin
                        chk("response", k, 64'({rsp_valid[k], rsp_id[k], rsp_data[k], rsp_neg[k]}),
                            64'({1'b1, 2'(rq[k][0].id), rq[k][0].a, rq[k][0].neg}));
                        void'(rq[k].pop_front());
                    end else begin
                        chk("no_rsp", k, 64'(rsp_valid[k]), 64'd0);
                    end
                end
            end
            if (end_req && !end_done) begin
                chk("queues_drained", 0, 64'(gq[0].size() + rq[0].size() + gq[1].size() + rq[1].size()), 64'd0);
                chk("driver_timeouts", 0, 64'(drv_fail), 64'd0);
                end_done = 1'b1;
            end
        end
    end

    // Stimulus
    initial begin
        for (int k = 0; k < 2; k++) begin
            pend[k] = '0; glitch[k] = '0; rearm[k] = 0;
        end
        model_reset();
        #2 nreset = 1'b0;

        // All four requesting while reset is held; requester 0 re-requests once.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) set_op(k, i, 16'h1000 * 16'(i + 1) + 16'h0011, 16'h0100 * 16'(i + 1));
            rearm[k] = 1;
        end
        repeat (4) tick();
        nreset = 1'b1;
        run_idle(200);

        // Pointer now at 1: requesters 3 and 0.
        for (int k = 0; k < 2; k++) begin
            set_op(k, 0, 16'h0500, 16'h0600);
            set_op(k, 3, 16'h7777, 16'h1111);
        end
        run_idle(100);

        for (int k = 0; k < 2; k++) set_op(k, 2, 16'h0030, 16'h0010);
        run_idle(50);
        for (int k = 0; k < 2; k++) set_op(k, 0, 16'h0001, 16'h0002);
        run_idle(50);
        for (int k = 0; k < 2; k++) set_op(k, 0, 16'h8000, 16'h8000);
        run_idle(50);

        // Reset while the operation sits in WAIT; its result must never appear.
        for (int k = 0; k < 2; k++) set_op(k, 2, 16'h1234, 16'h0034);
        begin
            int n;
            n = 0;
            while (cyc != lo[0] && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) drv_fail = 1'b1;
        end
        nreset = 1'b0;
        model_reset();
        repeat (2) tick();
        nreset = 1'b1;
        for (int k = 0; k < 2; k++) set_op(k, 1, 16'h00FF, 16'h0100);
        run_idle(50);

        // Random traffic with request glitches while busy.
        repeat (1500) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[k][i] && $urandom_range(3) == 0) set_op(k, i, rnd_op(), rnd_op());
                end
                if (cyc + 1 < free_e[k]) glitch[k] = 4'($urandom) & ~pend[k];
            end
            tick();
        end
        run_idle(200);

        end_req = 1'b1;
        repeat (3) @(negedge clock);
        if (!end_done) begin
            $display("FAIL end_check: final drain check did not run");
            $fatal(1, "end check missing");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
